shake_dout_collector: RTL and testbench
=======================================

# shake_dout_collector

Output-side receiver for the Keccak/SHAKE core's `dout` stream. It is the consumer that sits on the other end of the core's `dout`/`dout_valid`/`dout_ready` handshake. It accepts a requested number of `WIN`-bit squeeze words, packs them little-endian into `OUT_W`-bit beats on a valid/ready output, and drives the core's `force_done` once the requested length has been taken. It is used where SHAKE256 output feeds wider downstream datapaths, such as the HQC samplers.

## Interface
- `WIN`, 32: width of one core output word.
- `OUT_W`, 128: packed beat width. Must be an integer multiple of `WIN`; R = `OUT_W`/`WIN` ≥ 1.
- `LEN_W`, 16: width of the length request.
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: begin a collection; sampled only in IDLE.
- `out_len` in `LEN_W`: number of `WIN` words to collect; sampled with `start`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a collection completes.
- `force_done` out 1: one-cycle pulse to the core; requested length reached.
- `in_valid` in 1: core `dout_valid`.
- `in_ready` out 1: to core `dout_ready`.
- `in_data` in `WIN`: core `dout`.
- `out_valid` out 1: packed beat valid.
- `out_ready` in 1: downstream accept.
- `out_data` out `OUT_W`: packed beat.
- `out_last` out 1: qualifies the final beat of a collection.

## Operation
- **States:** IDLE, COLLECT, DRAIN, FINISH.
- **IDLE:**
  - When `start`=1 and `out_len`≠0: load remaining count `rem`←`out_len`, lane←0, packing register←0, go to COLLECT.
  - When `start`=1 and `out_len`=0: go directly to FINISH with `force_done` set. No beat is emitted.
- **COLLECT:**
  - A word is accepted on `in_valid`&&`in_ready`. It is written to lane `lane`, bits [lane·WIN +: WIN]. Lane 0 holds the first word (little-endian).
  - `in_ready` = (state==COLLECT) && (rem≠0) && (completing==0 || `out_valid`==0 || `out_ready`==1).
    - completing = (lane==R−1) || (rem==1).
  - On a completing accept, the packed value (including the current word) is transferred straight into the output register. `out_valid`←1, `out_last`←(rem==1), lane←0, packing register←0.
  - Otherwise lane←lane+1.
  - Every accept decrements `rem`.
  - **Partial final beat:** when `out_len` mod R ≠ 0, lanes above the last word are zero.
  - **Last word accepted (rem 1→0):** `force_done`←1 for exactly one cycle, then go to DRAIN.
- **DRAIN:**
  - `in_ready`=0. Words the core still presents are not accepted.
  - Wait for `out_valid`&&`out_ready` on the last beat, or go immediately if the beat was already taken. Then go to FINISH.
- **FINISH:** `done`←1 for one cycle, then go to IDLE.
- **Output register:**
  - `out_valid` clears on `out_valid`&&`out_ready` unless a new completing accept reloads it in the same cycle.
  - `out_data` and `out_last` hold stable while `out_valid`=1 && `out_ready`=0.
- `start` outside IDLE is ignored.
- `out_len` changes after sampling have no effect.
- **Reset mid-operation:** any state → IDLE. The partially packed word and any pending beat are discarded. No `done` or `force_done` is issued.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `force_done`=0, `in_ready`=0.
  - `out_valid`=0, `out_last`=0, `out_data`=0.
  - Internal state: IDLE, `rem`=0, lane=0.
- **Start:** `start` sampled at edge T. `busy` and `in_ready` go high after edge T, so the first accept can occur at edge T+1.
- **Beat latency:** a completing word accepted at edge N gives `out_valid`=1 after edge N. Latency is one cycle.
- **Throughput:** with `out_ready`=1, one word is accepted per cycle with no bubbles.
- **Backpressure:** when `out_valid`=1 and `out_ready`=0, `in_ready` drops only for the completing lane. Non-completing lanes continue to fill.
- **`force_done`:** high in the cycle after the edge that accepted the final word, i.e. the same cycle the final `out_valid` rises.
- **`done`:** high one cycle after the final beat handshake, or one cycle after entering FINISH. For `out_len`=0: `force_done` is high at T+1 and `done` at T+2.

## Test plan
1. R=4, `out_len`=8, `in_data`=0..7 streaming back-to-back, `out_ready`=1.
   - Two beats: 0x00000003_00000002_00000001_00000000, then 0x00000007_…_00000004.
   - `out_last` is set only on the second beat.
   - `force_done` pulses once, in the cycle the second beat becomes valid.
   - `done` pulses after the second beat is taken.
2. `out_len`=5, `in_data`=0..4.
   - Second beat is 0x00000000_00000000_00000000_00000004 with `out_last`=1.
   - Exactly 5 accepts occur.
3. `in_valid` and `out_ready` with ten-cycle wait gaps, `out_len`=12.
   - Three beats, no word lost or duplicated.
   - `in_ready` is low only when the completing lane is blocked by a held beat.
   - `out_data` is stable while stalled.
4. `out_len`=0.
   - No `in_ready` and no `out_valid`.
   - `force_done` at T+1, `done` at T+2, `busy` back to 0 at T+3.
5. `rst`=0 asserted after 3 of 8 words.
   - Next cycle: all outputs at reset values.
   - A fresh `start` then produces a correct first beat from new data.
6. After the final accept, `in_valid` is held at 1 and `start` is pulsed during DRAIN.
   - No further accepts, no second `force_done`, `start` ignored.
   - Exactly one `done`.

Source files
------------

// File: rtl/shake_dout_collector.sv
// Collects WIN-bit squeeze words from the Keccak/SHAKE core and packs them
// little-endian into OUT_W-bit beats; pulses force_done once the requested length is taken.
module shake_dout_collector #(
    parameter int unsigned WIN   = 32,
    parameter int unsigned OUT_W = 128,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len,
    output logic             busy,
    output logic             done,
    output logic             force_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIN-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last
);

    localparam int unsigned R     = OUT_W / WIN;
    localparam int unsigned LaneW = (R > 1) ? $clog2(R) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(R - 1);

    typedef enum logic [1:0] {StIdle, StCollect, StDrain, StFinish} state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [LaneW-1:0]   lane_q, lane_d;
    logic [OUT_W-1:0]   pack_q, pack_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               force_done_q, force_done_d;
    logic               done_q, done_d;
    logic               completing, accept;
    logic [OUT_W-1:0]   pack_word;

    assign completing = (lane_q == LastLane) || (rem_q == LEN_W'(1));
    assign in_ready   = (state_q == StCollect) && (rem_q != '0) &&
                        (!completing || !out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;

    // Packing register with the incoming word merged into the current lane.
    always_comb begin
        pack_word = pack_q;
        for (int unsigned i = 0; i < R; i++) begin
            if (lane_q == LaneW'(i)) pack_word[i*WIN +: WIN] = in_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        lane_d       = lane_q;
        pack_d       = pack_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_last_d   = out_last_q;
        force_done_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (out_len != '0) begin
                        rem_d   = out_len;
                        lane_d  = '0;
                        pack_d  = '0;
                        state_d = StCollect;
                    end else begin
                        force_done_d = 1'b1;
                        state_d      = StFinish;
                    end
                end
            end
            StCollect: begin
                if (accept) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (completing) begin
                        out_data_d  = pack_word;
                        out_valid_d = 1'b1;
                        out_last_d  = (rem_q == LEN_W'(1));
                        lane_d      = '0;
                        pack_d      = '0;
                    end else begin
                        lane_d = lane_q + LaneW'(1);
                        pack_d = pack_word;
                    end
                    if (rem_q == LEN_W'(1)) begin
                        force_done_d = 1'b1;
                        state_d      = StDrain;
                    end
                end
            end
            StDrain: begin
                if (!out_valid_q || out_ready) state_d = StFinish;
            end
            StFinish: begin
                // Stay one extra cycle so done is visible while still busy.
                done_d = !done_q;
                if (done_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            rem_q        <= '0;
            lane_q       <= '0;
            pack_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            force_done_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            force_done_q <= force_done_d;
            done_q       <= done_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign force_done = force_done_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

endmodule

// File: tb/tb_shake_dout_collector.sv
// Directed bench for shake_dout_collector with R=4 (WIN=32, OUT_W=128).
module tb_shake_dout_collector;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [15:0]  out_len = '0;
    logic         busy, done, force_done;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_last;

    shake_dout_collector #(.WIN(32), .OUT_W(128), .LEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .out_len    (out_len),
        .busy       (busy),
        .done       (done),
        .force_done (force_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor state, written only by the monitor process.
    int           cyc = 0, acc_n = 0, fd_cnt = 0, done_cnt = 0, hs_cyc = 0, done_cyc = 0;
    int           fd_bad = 0, ir_bad = 0, stab_bad = 0, ir_seen = 0, ov_seen = 0;
    logic [127:0] beat_q[$];
    logic         last_q[$];
    logic         prev_hold = 1'b0, prev_last = 1'b0, comp;
    logic [127:0] prev_data = '0;
    // Written only by the stimulus process.
    logic         clr_req = 1'b0;
    int           mon_len = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        cyc++;
        if (clr_req) begin
            acc_n = 0; fd_cnt = 0; done_cnt = 0; hs_cyc = 0; done_cyc = 0;
            fd_bad = 0; ir_bad = 0; stab_bad = 0; ir_seen = 0; ov_seen = 0;
            beat_q.delete(); last_q.delete(); prev_hold = 1'b0;
        end else if (rst) begin
            comp = ((acc_n % 4) == 3) || (acc_n == mon_len - 1);
            // While collecting, in_ready must be low exactly when the completing lane is blocked.
            if (busy && acc_n < mon_len && (in_ready == (comp && out_valid && !out_ready)))
                ir_bad++;
            if (in_ready) ir_seen++;
            if (out_valid) ov_seen++;
            if (prev_hold && (!out_valid || out_data !== prev_data || out_last !== prev_last))
                stab_bad++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            if (in_valid && in_ready) acc_n++;
            if (out_valid && out_ready) begin
                beat_q.push_back(out_data);
                last_q.push_back(out_last);
                if (out_last) hs_cyc = cyc;
            end
            if (force_done) begin
                fd_cnt++;
                if (mon_len != 0 && !(out_valid && out_last)) fd_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    function automatic logic [127:0] beat4(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic check_beat(input string tag, input int k, input logic [127:0] exp,
                              input logic exp_last);
        logic [127:0] got;
        logic         gl;
        got = (k < beat_q.size()) ? beat_q[k] : 'x;
        gl  = (k < last_q.size()) ? last_q[k] : 1'bx;
        check(tag, got, exp);
        check({tag, "_last"}, gl, exp_last);
    endtask

    task automatic clear_mon(input int len);
        mon_len = len;
        clr_req = 1'b1;
        @(negedge clk);
        #1 clr_req = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] len);
        clear_mon(len);
        @(posedge clk); #1;
        start   = 1'b1;
        out_len = len;
        @(posedge clk); #1;
        start   = 1'b0;
        out_len = 16'hbeef;
    endtask

    task automatic feed(input int n, input logic [31:0] base, input int gap_a, input int gap_b,
                        input int hold_extra);
        int i = 0;
        int t = 0;
        while (i < n && t < 3000) begin
            in_valid = 1'b1;
            in_data  = base + i;
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                if (i == gap_a || i == gap_b) begin
                    in_valid = 1'b0;
                    repeat (10) @(posedge clk);
                    #1;
                end
                i++;
            end else begin
                @(posedge clk); #1;
            end
            t++;
        end
        if (i < n) check("feed_timeout", i, n);
        in_data  = 32'hdead0000;
        in_valid = (hold_extra > 0);
        repeat (hold_extra) @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_cnt == 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        check("done_seen", done_cnt > 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fd", force_done, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 128'h0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: eight words back-to-back
        out_ready = 1'b1;
        do_start(16'd8);
        feed(8, 32'h0, -1, -1, 0);
        wait_done();
        check("t1_nbeats", beat_q.size(), 2);
        check_beat("t1_beat0", 0, 128'h00000003_00000002_00000001_00000000, 1'b0);
        check_beat("t1_beat1", 1, 128'h00000007_00000006_00000005_00000004, 1'b1);
        check("t1_fd_cnt", fd_cnt, 1);
        check("t1_fd_align", fd_bad, 0);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_lat", done_cyc - hs_cyc, 2);
        check("t1_in_ready", ir_bad, 0);
        check("t1_busy_end", busy, 1'b0);

        // 2: partial final beat, core keeps offering words afterwards
        do_start(16'd5);
        feed(5, 32'h0, -1, -1, 3);
        wait_done();
        check("t2_accepts", acc_n, 5);
        check("t2_nbeats", beat_q.size(), 2);
        check_beat("t2_beat0", 0, 128'h00000003_00000002_00000001_00000000, 1'b0);
        check_beat("t2_beat1", 1, 128'h00000000_00000000_00000000_00000004, 1'b1);

        // 3: gaps on both sides
        out_ready = 1'b0;
        do_start(16'd12);
        fork
            feed(12, 32'h10, 2, 7, 0);
            begin
                for (int k = 0; k < 800 && done_cnt == 0; k++) begin
                    out_ready = ((k % 11) == 10);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_done();
        check("t3_accepts", acc_n, 12);
        check("t3_nbeats", beat_q.size(), 3);
        check_beat("t3_beat0", 0, beat4(32'h10), 1'b0);
        check_beat("t3_beat1", 1, beat4(32'h14), 1'b0);
        check_beat("t3_beat2", 2, beat4(32'h18), 1'b1);
        check("t3_in_ready", ir_bad, 0);
        check("t3_stable", stab_bad, 0);
        check("t3_fd_cnt", fd_cnt, 1);
        check("t3_done_cnt", done_cnt, 1);

        // 4: zero-length request
        out_ready = 1'b1;
        clear_mon(0);
        @(posedge clk); #1;
        start   = 1'b1;
        out_len = 16'd0;
        @(posedge clk); #1;
        start   = 1'b0;
        @(negedge clk);
        check("t4_fd_t1", force_done, 1'b1);
        check("t4_done_t1", done, 1'b0);
        @(negedge clk);
        check("t4_fd_t2", force_done, 1'b0);
        check("t4_done_t2", done, 1'b1);
        check("t4_busy_t2", busy, 1'b1);
        @(negedge clk);
        check("t4_busy_t3", busy, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t4_no_in_ready", ir_seen, 0);
        check("t4_no_out_valid", ov_seen, 0);
        check("t4_done_cnt", done_cnt, 1);

        // 5: reset after three of eight words
        do_start(16'd8);
        feed(3, 32'h50, -1, -1, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_in_ready", in_ready, 1'b0);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_out_last", out_last, 1'b0);
        check("t5_out_data", out_data, 128'h0);
        check("t5_fd", force_done, 1'b0);
        check("t5_done", done, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        do_start(16'd4);
        feed(4, 32'ha0, -1, -1, 0);
        wait_done();
        check("t5_nbeats", beat_q.size(), 1);
        check_beat("t5_beat0", 0, 128'h000000a3_000000a2_000000a1_000000a0, 1'b1);

        // 6: core keeps pushing and start pulses while draining
        out_ready = 1'b0;
        do_start(16'd4);
        feed(4, 32'h60, -1, -1, 0);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        start    = 1'b1;
        out_len  = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("t6_busy_drain", busy, 1'b1);
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy_idle", busy, 1'b0);
        in_valid = 1'b0;
        check("t6_accepts", acc_n, 4);
        check("t6_fd_cnt", fd_cnt, 1);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_nbeats", beat_q.size(), 1);
        check_beat("t6_beat0", 0, beat4(32'h60), 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
